// File: rtl/dual_fetch_unit_if.sv
// Instruction-memory bus between the dual fetch unit and a dual-port
// synchronous instruction memory.
//   imem_req            : read request this cycle (fetch unit -> memory)
//   imem_addr0/1        : word addresses of the pipeline-0 / pipeline-1 words
//   imem_rdata0/1       : read data, valid the cycle after imem_req
// Modports: master = fetch unit, slave = memory.
interface dual_fetch_unit_if #(
   parameter int PC_W = 8,
   parameter int IR_W = 16
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr0;
   logic [PC_W-1:0] imem_addr1;
   logic [IR_W-1:0] imem_rdata0;
   logic [IR_W-1:0] imem_rdata1;

   modport master (
      output imem_req,
      output imem_addr0,
      output imem_addr1,
      input  imem_rdata0,
      input  imem_rdata1
   );

   modport slave (
      input  imem_req,
      input  imem_addr0,
      input  imem_addr1,
      output imem_rdata0,
      output imem_rdata1
   );
endinterface

// File: rtl/dual_fetch_unit.sv
// Dual-issue instruction fetch front end.
// Fetches (PC, PC+1) pairs from a dual-port synchronous instruction memory,
// buffers them in a pair FIFO and presents the FIFO head to pipelines 0/1.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   fetch_en          : allow new memory requests
//   fetch_next        : consume the head pair (when issue_valid)
//   redirect/_pc      : flush the buffer and restart fetch at redirect_pc
//   imem              : instruction-memory bus (master side)
//   p0/p1_IR_out      : head instructions (NOP_INST when empty)
//   p0/p1_PC_out      : head PCs (hold last shown values when empty)
//   issue_valid       : head pair valid
//   fifo_count        : occupied FIFO entries

// Overflow checker: a push must never find the FIFO full.
module dual_fetch_unit_chk #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk,
   input logic          rst,
   input logic          redirect,
   input logic          push,
   input logic [CW-1:0] count
);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   // Flag any accepted push into a full FIFO.
   always @(posedge clk) begin
      if (!rst && !redirect && push) begin
         assert (count != FULL_C) else $error("dual_fetch_unit: pair FIFO overflow");
      end
   end
endmodule

module dual_fetch_unit #(
   parameter int              DEPTH    = 4,
   parameter int              PC_W     = 8,
   parameter int              IR_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00,
   parameter logic [IR_W-1:0] NOP_INST = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_en,
   input  logic                     fetch_next,
   input  logic                     redirect,
   input  logic [PC_W-1:0]          redirect_pc,
   dual_fetch_unit_if.master        imem,
   output logic [IR_W-1:0]          p0_IR_out,
   output logic [IR_W-1:0]          p1_IR_out,
   output logic [PC_W-1:0]          p0_PC_out,
   output logic [PC_W-1:0]          p1_PC_out,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam int                AW      = $clog2(DEPTH);
   localparam logic [AW+1:0]     DEPTH_L = (AW+2)'(DEPTH);
   localparam logic [AW:0]       PTR_ZERO = {(AW+1){1'b0}};
   localparam logic [PC_W-1:0]   PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [PC_W-1:0]   PC_TWO  = PC_ONE << 1;

   logic [PC_W-1:0] fetch_pc_r;
   logic [PC_W-1:0] req_pc_r;
   logic            inflight_r;
   logic [AW:0]     wr_ptr_r;
   logic [AW:0]     rd_ptr_r;
   logic [IR_W-1:0] ir0_mem_r [DEPTH];
   logic [IR_W-1:0] ir1_mem_r [DEPTH];
   logic [PC_W-1:0] pc_mem_r  [DEPTH];

   logic [AW:0]     count_s;
   logic [AW:0]     rd_next_s;
   logic [AW:0]     wr_next_s;
   logic [AW:0]     count_next_s;
   logic [AW+1:0]   occupancy_s;
   logic            req_s;
   logic            push_s;
   logic            pop_s;
   logic            head_valid_s;
   logic [IR_W-1:0] head_ir0_s;
   logic [IR_W-1:0] head_ir1_s;
   logic [PC_W-1:0] head_pc0_s;
   logic [PC_W-1:0] head_pc1_s;

   assign imem.imem_req   = req_s;
   assign imem.imem_addr0 = fetch_pc_r;
   assign imem.imem_addr1 = fetch_pc_r + PC_ONE;
   assign fifo_count      = count_s;

   // Request/pop decisions and the head pair the outputs will show next cycle.
   always_comb begin
      count_s      = wr_ptr_r - rd_ptr_r;
      // The in-flight read already owns a slot, so a push can never overflow.
      occupancy_s  = {1'b0, count_s} + (AW+2)'(inflight_r);
      req_s        = fetch_en & ~rst & ~redirect & (occupancy_s < DEPTH_L);
      push_s       = inflight_r;
      pop_s        = fetch_next & (count_s != PTR_ZERO) & ~redirect;
      rd_next_s    = rd_ptr_r + (AW+1)'(pop_s);
      wr_next_s    = wr_ptr_r + (AW+1)'(push_s);
      count_next_s = wr_next_s - rd_next_s;
      head_valid_s = 1'b0;
      head_ir0_s   = NOP_INST;
      head_ir1_s   = NOP_INST;
      head_pc0_s   = p0_PC_out;
      head_pc1_s   = p1_PC_out;
      if (count_next_s == PTR_ZERO) begin
         head_valid_s = 1'b0;
      end else if (rd_next_s == wr_ptr_r) begin
         // Next head is the pair being pushed right now: forward it.
         head_valid_s = 1'b1;
         head_ir0_s   = imem.imem_rdata0;
         head_ir1_s   = imem.imem_rdata1;
         head_pc0_s   = req_pc_r;
         head_pc1_s   = req_pc_r + PC_ONE;
      end else begin
         head_valid_s = 1'b1;
         head_ir0_s   = ir0_mem_r[rd_next_s[AW-1:0]];
         head_ir1_s   = ir1_mem_r[rd_next_s[AW-1:0]];
         head_pc0_s   = pc_mem_r[rd_next_s[AW-1:0]];
         head_pc1_s   = pc_mem_r[rd_next_s[AW-1:0]] + PC_ONE;
      end
   end

   // Pair storage; writes only for a push that survives reset and redirect.
   always_ff @(posedge clk) begin
      if (!rst && !redirect && push_s) begin
         ir0_mem_r[wr_ptr_r[AW-1:0]] <= imem.imem_rdata0;
         ir1_mem_r[wr_ptr_r[AW-1:0]] <= imem.imem_rdata1;
         pc_mem_r[wr_ptr_r[AW-1:0]]  <= req_pc_r;
      end
   end

   // Fetch PC, in-flight tracking, FIFO pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r  <= RESET_PC;
         req_pc_r    <= RESET_PC;
         inflight_r  <= 1'b0;
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         issue_valid <= 1'b0;
         p0_IR_out   <= NOP_INST;
         p1_IR_out   <= NOP_INST;
         p0_PC_out   <= {PC_W{1'b0}};
         p1_PC_out   <= {PC_W{1'b0}};
      end else if (redirect) begin
         // Flush and drop the in-flight response; PC outputs hold.
         fetch_pc_r  <= redirect_pc;
         inflight_r  <= 1'b0;
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         issue_valid <= 1'b0;
         p0_IR_out   <= NOP_INST;
         p1_IR_out   <= NOP_INST;
      end else begin
         inflight_r <= req_s;
         if (req_s) begin
            fetch_pc_r <= fetch_pc_r + PC_TWO;
            req_pc_r   <= fetch_pc_r;
         end
         wr_ptr_r    <= wr_next_s;
         rd_ptr_r    <= rd_next_s;
         issue_valid <= head_valid_s;
         p0_IR_out   <= head_ir0_s;
         p1_IR_out   <= head_ir1_s;
         p0_PC_out   <= head_pc0_s;
         p1_PC_out   <= head_pc1_s;
      end
   end

   dual_fetch_unit_chk #(.DEPTH(DEPTH), .CW(AW+1)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .redirect (redirect),
      .push     (push_s),
      .count    (count_s)
   );
endmodule

// File: tb/tb_dual_fetch_unit.sv
// Self-checking bench for dual_fetch_unit: directed phases plus a random
// phase, compared every cycle against a queue-based reference model.
module tb_dual_fetch_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fetch_en = 1'b0;
   logic       fetch_next = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic [15:0] p0_IR_out, p1_IR_out;
   logic [7:0]  p0_PC_out, p1_PC_out;
   logic        issue_valid;
   logic [2:0]  fifo_count;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] q[$];
   logic [7:0] m_fetch_pc = 8'h00;
   logic [7:0] m_inflight_pc = 8'h00;
   bit         m_inflight = 1'b0;
   logic [7:0] m_shown0 = 8'h00;
   logic [7:0] m_shown1 = 8'h00;

   dual_fetch_unit_if #(.PC_W(8), .IR_W(16)) imem_bus ();

   dual_fetch_unit #(.DEPTH(4), .PC_W(8), .IR_W(16), .RESET_PC(8'h00), .NOP_INST(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_en    (fetch_en),
      .fetch_next  (fetch_next),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem_bus),
      .p0_IR_out   (p0_IR_out),
      .p1_IR_out   (p1_IR_out),
      .p0_PC_out   (p0_PC_out),
      .p1_PC_out   (p1_PC_out),
      .issue_valid (issue_valid),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   // instruction memory: word[a] = 16'h1000 + a, one-cycle read latency
   always @(posedge clk) begin
      if (imem_bus.imem_req) begin
         imem_bus.imem_rdata0 <= 16'h1000 + {8'h00, imem_bus.imem_addr0};
         imem_bus.imem_rdata1 <= 16'h1000 + {8'h00, imem_bus.imem_addr1};
      end else begin
         imem_bus.imem_rdata0 <= 16'hBAD0;
         imem_bus.imem_rdata1 <= 16'hBAD1;
      end
   end

   function automatic logic [15:0] word(input logic [7:0] a);
      return 16'h1000 + {8'h00, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: drive inputs, check outputs against the model, advance the model
   task automatic cycle(input bit r, input bit fe, input bit fn, input bit rd, input logic [7:0] rpc);
      bit exp_req;
      bit do_pop;
      logic [7:0] nxt;
      @(negedge clk);
      rst = r; fetch_en = fe; fetch_next = fn; redirect = rd; redirect_pc = rpc;
      #1;
      exp_req = fe && !r && !rd && ((q.size() + int'(m_inflight)) < 4);
      chk("imem_req", imem_bus.imem_req, exp_req);
      chk("imem_addr0", imem_bus.imem_addr0, m_fetch_pc);
      nxt = m_fetch_pc + 8'h01;
      chk("imem_addr1", imem_bus.imem_addr1, nxt);
      chk("fifo_count", fifo_count, q.size());
      if (q.size() != 0) begin
         nxt = q[0] + 8'h01;
         chk("issue_valid", issue_valid, 1'b1);
         chk("p0_IR", p0_IR_out, word(q[0]));
         chk("p1_IR", p1_IR_out, word(nxt));
         chk("p0_PC", p0_PC_out, q[0]);
         chk("p1_PC", p1_PC_out, nxt);
      end else begin
         chk("issue_valid_empty", issue_valid, 1'b0);
         chk("p0_IR_nop", p0_IR_out, 16'h0000);
         chk("p1_IR_nop", p1_IR_out, 16'h0000);
         chk("p0_PC_hold", p0_PC_out, m_shown0);
         chk("p1_PC_hold", p1_PC_out, m_shown1);
      end
      if (r) begin
         q.delete(); m_inflight = 1'b0; m_fetch_pc = 8'h00;
         m_shown0 = 8'h00; m_shown1 = 8'h00;
      end else if (rd) begin
         q.delete(); m_inflight = 1'b0; m_fetch_pc = rpc;
      end else begin
         do_pop = fn && (q.size() != 0);
         if (do_pop) void'(q.pop_front());
         if (m_inflight) q.push_back(m_inflight_pc);
         m_inflight = exp_req;
         if (exp_req) begin
            m_inflight_pc = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 8'h02;
         end
      end
      if (q.size() != 0) begin
         m_shown0 = q[0];
         m_shown1 = q[0] + 8'h01;
      end
   endtask

   initial begin
      int guard;
      // reset for two edges before checking
      @(posedge clk);
      @(posedge clk);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

      // startup: fetch_en and fetch_next held high
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

      // backpressure then drain
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++)  cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

      // reach count=3 with a read in flight, then redirect to 8'h41
      guard = 0;
      while (!(q.size() == 3 && m_inflight) && guard < 30) begin
         cycle(1'b0, 1'b1, q.size() == 4, 1'b0, 8'h00);
         guard++;
      end
      chk("reach_count3_inflight", guard < 30, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h41);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // PC wrap
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hFE);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

      // fetch disabled: drain to empty, pops ignored, then resume
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++)  cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

      // random phase
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
               8'($urandom));
      end

      // reset mid-stream with count=2 and a read in flight
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      guard = 0;
      while (!(q.size() == 2 && m_inflight) && guard < 30) begin
         cycle(1'b0, 1'b1, q.size() > 2, 1'b0, 8'h00);
         guard++;
      end
      chk("reach_count2_inflight", guard < 30, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
